// File: rtl/uart_pkg.sv
// Shared definitions for the UART line editor: FSM state codes, character
// constants and the printable-range helper.
package uart_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_P0   = 4'd1;
  localparam state_t ST_P1   = 4'd2;
  localparam state_t ST_WAIT = 4'd3;
  localparam state_t ST_RD   = 4'd4;
  localparam state_t ST_BS1  = 4'd5;
  localparam state_t ST_BS2  = 4'd6;
  localparam state_t ST_LF   = 4'd7;
  localparam state_t ST_DONE = 4'd8;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_BEL = 8'h07;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_SP  = 8'h20;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/uart_line_editor_if.sv
// Bundle of the UART byte streams and the line-consumer handshake/read port.
interface uart_line_editor_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       get_a_cmd;
  logic       idle;
  logic       line_valid;
  logic       line_ready;
  logic [7:0] line_len;
  logic [7:0] line_rd_addr;
  logic [7:0] line_rd_data;
  logic       rx_overflow;

  modport slave (
    input  rx_data, rx_ready, tx_busy, get_a_cmd, line_ready, line_rd_addr,
    output tx_start, tx_data, idle, line_valid, line_len, line_rd_data, rx_overflow
  );

  modport master (
    output rx_data, rx_ready, tx_busy, get_a_cmd, line_ready, line_rd_addr,
    input  tx_start, tx_data, idle, line_valid, line_len, line_rd_data, rx_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with extra-MSB pointers and a sticky drop flag.
// A push into a full FIFO is honoured when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign dout     = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_line_editor.sv
// Line editor between the UART RX/TX cores and the command decoder: prompt,
// echo, backspace editing, length limit and hand-off of the finished line.
//   state | meaning
//   IDLE  | waiting for get_a_cmd
//   P0/P1 | sending the two prompt bytes
//   WAIT  | letting the transmitter drain before reading again
//   RD    | consuming one RX byte and dispatching on it
//   BS1/2 | finishing the backspace-space-backspace erase sequence
//   LF    | sending LF after CR
//   DONE  | presenting the line until the consumer accepts it
module uart_line_editor #(
  parameter int         RBUF_DEPTH = 4,
  parameter int         LINE_MAX   = 32,
  parameter logic [7:0] PROMPT0    = 8'h24,
  parameter logic [7:0] PROMPT1    = 8'h20,
  parameter bit         ECHO_EN    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  uart_line_editor_if.slave bus
);
  import uart_pkg::*;

  localparam int         RAM_AW     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [7:0] LINE_MAX_B = 8'(LINE_MAX);

  state_t     state_q, state_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       line_valid_q, line_valid_d;
  logic [7:0] line_len_q, line_len_d;
  logic [7:0] line_mem [2**RAM_AW];
  logic       fifo_pop, fifo_empty, fifo_full_unused;
  logic [7:0] fifo_dout;
  logic       ram_we;
  logic       can_tx;

  uart_rx_fifo #(.DEPTH(RBUF_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.rx_ready),
    .din      (bus.rx_data),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full_unused),
    .overflow (bus.rx_overflow)
  );

  assign can_tx           = !tx_start_q && !bus.tx_busy;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.line_len     = line_len_q;
  assign bus.idle         = (state_q == ST_IDLE) && fifo_empty && !line_valid_q;
  assign bus.line_rd_data = (bus.line_rd_addr < LINE_MAX_B) ?
                            line_mem[bus.line_rd_addr[RAM_AW-1:0]] : 8'h00;

  always_comb begin
    state_d      = state_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    line_valid_d = line_valid_q;
    line_len_d   = line_len_q;
    fifo_pop     = 1'b0;
    ram_we       = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.get_a_cmd) begin
        line_len_d = 8'd0;
        state_d    = ST_P0;
      end
      ST_P0: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_data_d  = PROMPT0;
        state_d    = ST_P1;
      end
      ST_P1: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_data_d  = PROMPT1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: if (can_tx) state_d = ST_RD;
      // Popping only with the transmitter free lets every branch send at once.
      ST_RD: if (can_tx && !fifo_empty) begin
        fifo_pop = 1'b1;
        if (fifo_dout == CH_CR || fifo_dout == CH_LF) begin
          tx_start_d = 1'b1;
          tx_data_d  = CH_CR;
          state_d    = ST_LF;
        end else if (fifo_dout == CH_BS || fifo_dout == CH_DEL) begin
          if (line_len_q != 8'd0) begin
            line_len_d = line_len_q - 8'd1;
            tx_start_d = 1'b1;
            tx_data_d  = CH_BS;
            state_d    = ST_BS1;
          end
        end else if (is_printable(fifo_dout)) begin
          if (line_len_q < LINE_MAX_B) begin
            ram_we     = 1'b1;
            line_len_d = line_len_q + 8'd1;
            if (ECHO_EN) begin
              tx_start_d = 1'b1;
              tx_data_d  = fifo_dout;
              state_d    = ST_WAIT;
            end
          end else begin
            tx_start_d = 1'b1;
            tx_data_d  = CH_BEL;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_BS1: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_data_d  = CH_SP;
        state_d    = ST_BS2;
      end
      ST_BS2: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_data_d  = CH_BS;
        state_d    = ST_WAIT;
      end
      ST_LF: if (can_tx) begin
        tx_start_d = 1'b1;
        tx_data_d  = CH_LF;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (line_valid_q) begin
          if (bus.line_ready) begin
            line_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end
        end else if (can_tx) begin
          line_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      line_valid_q <= 1'b0;
      line_len_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      line_valid_q <= line_valid_d;
      line_len_q   <= line_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) line_mem[line_len_q[RAM_AW-1:0]] <= fifo_dout;
  end

endmodule

// File: tb/tb_uart_line_editor.sv
// Scoreboard bench for uart_line_editor: one echoing DUT with a short line
// limit and one silent DUT, sharing clock and reset.
module tb_uart_line_editor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_a = 0;
  int   busy_b = 0;
  int   last_tx_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  uart_line_editor_if if_a();
  uart_line_editor_if if_b();

  uart_line_editor #(.RBUF_DEPTH(4), .LINE_MAX(4), .PROMPT0(8'h24), .PROMPT1(8'h20),
                     .ECHO_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  uart_line_editor #(.RBUF_DEPTH(4), .LINE_MAX(32), .PROMPT0(8'h24), .PROMPT1(8'h20),
                     .ECHO_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Transmitter model: busy for three sampling points after each start.
  always @(negedge clk) begin
    cyc++;
    if (if_a.tx_start === 1'b1) begin
      chk("tx_gap_a", 32'(busy_a), 32'd0);
      if (exp_a.size() == 0) chk("tx_extra_a", 32'(if_a.tx_data), 32'h100);
      else chk("tx_a", 32'(if_a.tx_data), 32'(exp_a.pop_front()));
      busy_a = 3;
    end else if (busy_a > 0) busy_a--;
    if_a.tx_busy = (busy_a != 0);
    if (if_b.tx_start === 1'b1) begin
      chk("tx_gap_b", 32'(busy_b), 32'd0);
      if (exp_b.size() == 0) chk("tx_extra_b", 32'(if_b.tx_data), 32'h100);
      else chk("tx_b", 32'(if_b.tx_data), 32'(exp_b.pop_front()));
      busy_b = 3;
      last_tx_b = cyc;
    end else if (busy_b > 0) busy_b--;
    if_b.tx_busy = (busy_b != 0);
  end

  function automatic logic valid_of(input int d);
    return (d == 0) ? if_a.line_valid : if_b.line_valid;
  endfunction

  function automatic logic idle_of(input int d);
    return (d == 0) ? if_a.idle : if_b.idle;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_a.size() : exp_b.size();
  endfunction

  task automatic drive_rx(input int d, input logic [7:0] b, input logic v);
    if (d == 0) begin if_a.rx_data = b; if_a.rx_ready = v; end
    else begin if_b.rx_data = b; if_b.rx_ready = v; end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    @(negedge clk); drive_rx(d, b, 1'b1);
    @(negedge clk); drive_rx(d, 8'h00, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input int d, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(d, s[i], gap);
  endtask

  task automatic expect_byte(input int d, input logic [7:0] b);
    if (d == 0) exp_a.push_back(b); else exp_b.push_back(b);
  endtask

  task automatic expect_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) expect_byte(d, s[i]);
  endtask

  task automatic get_cmd(input int d);
    @(negedge clk);
    if (d == 0) if_a.get_a_cmd = 1'b1; else if_b.get_a_cmd = 1'b1;
    @(negedge clk);
    if_a.get_a_cmd = 1'b0; if_b.get_a_cmd = 1'b0;
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    while (qsize(d) != 0 && n < budget) begin @(negedge clk); #1; n++; end
    chk("tx_drained", 32'(qsize(d)), 32'd0);
  endtask

  task automatic wait_line(input int d, input int len, input string s);
    int n = 0;
    while (valid_of(d) !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("line_valid", 32'(valid_of(d)), 32'd1);
    chk("line_len", 32'((d == 0) ? if_a.line_len : if_b.line_len), 32'(len));
    for (int i = 0; i < len; i++) begin
      if_a.line_rd_addr = 8'(i); if_b.line_rd_addr = 8'(i);
      #1;
      chk("line_ram", 32'((d == 0) ? if_a.line_rd_data : if_b.line_rd_data), 32'(s[i]));
    end
    chk("tx_done_before_valid", 32'(qsize(d)), 32'd0);
  endtask

  task automatic accept_line(input int d);
    @(negedge clk);
    if (d == 0) if_a.line_ready = 1'b1; else if_b.line_ready = 1'b1;
    @(negedge clk);
    if_a.line_ready = 1'b0; if_b.line_ready = 1'b0;
    chk("valid_after_ack", 32'(valid_of(d)), 32'd0);
    chk("idle_after_ack", 32'(idle_of(d)), 32'd1);
  endtask

  initial begin
    int n;
    string fill, strm;
    if_a.rx_data = 8'h00; if_a.rx_ready = 1'b0; if_a.get_a_cmd = 1'b0;
    if_a.line_ready = 1'b0; if_a.line_rd_addr = 8'h00;
    if_b.rx_data = 8'h00; if_b.rx_ready = 1'b0; if_b.get_a_cmd = 1'b0;
    if_b.line_ready = 1'b0; if_b.line_rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(if_a.tx_start), 32'd0);
    chk("rst_tx_data", 32'(if_a.tx_data), 32'd0);
    chk("rst_line_valid", 32'(if_a.line_valid), 32'd0);
    chk("rst_line_len", 32'(if_a.line_len), 32'd0);
    chk("rst_overflow", 32'(if_a.rx_overflow), 32'd0);
    chk("rst_idle", 32'(if_a.idle), 32'd1);
    rst = 1'b0;

    // Prompt and echo, consumer holding off
    expect_str(0, "$ ab"); expect_byte(0, 8'h0D); expect_byte(0, 8'h0A);
    get_cmd(0);
    send_str(0, "ab", 20);
    send_byte(0, 8'h0D, 0);
    wait_line(0, 2, "ab");
    repeat (5) @(negedge clk);
    chk("valid_hold", 32'(if_a.line_valid), 32'd1);
    chk("len_hold", 32'(if_a.line_len), 32'd2);
    accept_line(0);

    // Backspace
    expect_str(0, "$ abc"); expect_byte(0, 8'h08); expect_byte(0, 8'h20);
    expect_byte(0, 8'h08); expect_byte(0, 8'h0D); expect_byte(0, 8'h0A);
    get_cmd(0);
    send_str(0, "abc", 20);
    send_byte(0, 8'h08, 20);
    send_byte(0, 8'h0D, 0);
    wait_line(0, 2, "ab");
    accept_line(0);

    // DEL on an empty line is silent
    expect_str(0, "$ ");
    get_cmd(0);
    send_byte(0, 8'h7F, 30);
    chk("del_empty_quiet", 32'(exp_a.size()), 32'd0);
    expect_byte(0, 8'h0D); expect_byte(0, 8'h0A);
    send_byte(0, 8'h0D, 0);
    wait_line(0, 0, "");
    accept_line(0);

    // Line full rings BEL
    expect_str(0, "$ abcd"); expect_byte(0, 8'h07); expect_byte(0, 8'h07);
    expect_byte(0, 8'h0D); expect_byte(0, 8'h0A);
    get_cmd(0);
    send_str(0, "abcdef", 20);
    send_byte(0, 8'h0D, 0);
    wait_line(0, 4, "abcd");
    accept_line(0);

    // Overflow while idle
    chk("ovf_before", 32'(if_a.rx_overflow), 32'd0);
    fill = "vwxyz";
    for (int i = 0; i < 5; i++) begin @(negedge clk); drive_rx(0, fill[i], 1'b1); end
    @(negedge clk); drive_rx(0, 8'h00, 1'b0);
    chk("ovf_set", 32'(if_a.rx_overflow), 32'd1);
    chk("idle_fifo_busy", 32'(if_a.idle), 32'd0);
    expect_str(0, "$ vwxy");
    get_cmd(0);
    drain(0, 300);
    expect_byte(0, 8'h0D); expect_byte(0, 8'h0A);
    send_byte(0, 8'h0D, 0);
    wait_line(0, 4, "vwxy");
    accept_line(0);

    // Reset during the erase sequence
    expect_str(0, "$ ab"); expect_byte(0, 8'h08);
    get_cmd(0);
    send_str(0, "ab", 20);
    send_byte(0, 8'h08, 0);
    drain(0, 200);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_start", 32'(if_a.tx_start), 32'd0);
    chk("mid_rst_idle", 32'(if_a.idle), 32'd1);
    chk("mid_rst_valid", 32'(if_a.line_valid), 32'd0);
    chk("mid_rst_overflow", 32'(if_a.rx_overflow), 32'd0);
    chk("mid_rst_len", 32'(if_a.line_len), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // ESC and silent entry
    expect_str(1, "$ "); expect_byte(1, 8'h0D); expect_byte(1, 8'h0A);
    get_cmd(1);
    send_byte(1, 8'h1B, 10);
    send_byte(1, 8'h78, 10);
    send_byte(1, 8'h0D, 0);
    wait_line(1, 1, "x");
    accept_line(1);

    // Full FIFO with push and pop in the same cycle
    chk("ovf_b_before", 32'(if_b.rx_overflow), 32'd0);
    expect_str(1, "$ ");
    get_cmd(1);
    fill = "ABCD";
    for (int i = 0; i < 4; i++) begin @(negedge clk); drive_rx(1, fill[i], 1'b1); end
    @(negedge clk); drive_rx(1, 8'h00, 1'b0);
    drain(1, 100);
    n = 0;
    while (cyc != last_tx_b + 4 && n < 50) begin @(negedge clk); #1; n++; end
    chk("stream_align", 32'(cyc - last_tx_b), 32'd4);
    strm = "EFGH";
    drive_rx(1, strm[0], 1'b1);
    for (int i = 1; i < 4; i++) begin @(negedge clk); #1; drive_rx(1, strm[i], 1'b1); end
    @(negedge clk); #1; drive_rx(1, 8'h00, 1'b0);
    chk("ovf_b_after", 32'(if_b.rx_overflow), 32'd0);
    expect_byte(1, 8'h0D); expect_byte(1, 8'h0A);
    send_byte(1, 8'h0D, 0);
    wait_line(1, 8, "ABCDEFGH");
    accept_line(1);

    repeat (10) @(negedge clk);
    chk("final_q_a", 32'(exp_a.size()), 32'd0);
    chk("final_q_b", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_line_editor.md
Name: uart_line_editor

Overview:
- Parametrised successor to the UART echo unit. Sits between the UART RX/TX cores and the command decoder.
- Buffers received bytes in a configurable FIFO and echoes them with a configurable two-byte prompt.
- Handles backspace/DEL editing and enforces a maximum line length, ringing BEL when the line is full.
- Stores the edited line in an internal line RAM and hands a completed line to the consumer with a valid/ready handshake and a random-access read port.

Parameters:
- RBUF_DEPTH, 4, RX FIFO depth; power of two, at least 2.
- LINE_MAX, 32, maximum stored characters per line; 1..255.
- PROMPT0, 8'h24 ("$"), first prompt byte.
- PROMPT1, 8'h20 (" "), second prompt byte.
- ECHO_EN, 1, 1 = echo printable characters; 0 = silent entry (editing sequences, BEL and CR/LF are still sent).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- rx_data, in, 8, received byte.
- rx_ready, in, 1, one-cycle strobe: rx_data is valid.
- tx_start, out, 1, one-cycle strobe: send tx_data.
- tx_data, out, 8, byte to transmit.
- tx_busy, in, 1, transmitter busy.
- get_a_cmd, in, 1, request to start a new line (prompt then edit).
- idle, out, 1, high when state is IDLE, the FIFO is empty and line_valid is low.
- line_valid, out, 1, a completed line is available.
- line_ready, in, 1, consumer accepts the line.
- line_len, out, 8, number of stored characters; stable while line_valid is high.
- line_rd_addr, in, 8, line RAM read address.
- line_rd_data, out, 8, combinational read: line RAM at line_rd_addr.
- rx_overflow, out, 1, sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high):
  - tx_start=0, tx_data=0, line_valid=0, line_len=0, rx_overflow=0.
  - FIFO pointers cleared; state = IDLE.
  - Reset mid-transmission simply abandons the sequence. Line RAM contents are don't-care.
- RX FIFO:
  - Pointers are log2(RBUF_DEPTH)+1 bits; empty when the pointers are equal, full when the MSBs differ and the rest are equal.
  - Push on rx_ready when not full. If the FIFO is full and no pop occurs that cycle, drop the byte and set rx_overflow.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - Pops occur only in state RD when the FIFO is not empty; at most one per cycle.
  - The FIFO keeps accepting bytes in every state.
- TX rule (all transmitting states):
  - The state drives tx_start=1 for exactly one cycle together with tx_data.
  - The next byte may be issued only when tx_start=0 and tx_busy=0.
  - Each transmitting state waits for that condition before advancing.
- States:
  - IDLE: tx_start=0. On get_a_cmd, clear line_len and go to P0. get_a_cmd is ignored in all other states.
  - P0: send PROMPT0, then P1.
  - P1: send PROMPT1, then WAIT.
  - WAIT: hold until tx_start=0 and tx_busy=0, then RD.
  - RD: pop the head byte b, then:
    - b = 0x0D or 0x0A: send 0x0D, go to LF.
    - b = 0x08 or 0x7F with line_len>0: decrement line_len, send 0x08, go to BS1.
    - b = 0x08 or 0x7F with line_len=0: no output, stay in RD.
    - 0x20 <= b <= 0x7E with line_len<LINE_MAX: write line RAM[line_len]=b, increment line_len. If ECHO_EN, send b and go to WAIT; otherwise stay in RD.
    - Printable b with line_len=LINE_MAX: drop b, send 0x07, go to WAIT.
    - Any other byte (ESC, other control codes): ignored, stay in RD.
  - BS1: send 0x20, then BS2.
  - BS2: send 0x08, then WAIT.
  - LF: send 0x0A, then DONE.
  - DONE: wait for TX idle, then raise line_valid. Hold line_valid, line_len and the RAM until a cycle with line_valid && line_ready; in that cycle clear line_valid and go to IDLE.
- Boundaries:
  - A CRLF pair yields an empty second line only if get_a_cmd is issued again; the LF stays queued in the FIFO until then.
  - line_len never wraps in either direction.
  - The line RAM write index is always < LINE_MAX.

Decomposition:
- Shared package uart_pkg:
  - State enumeration.
  - Character constants: CR, LF, BS, DEL, BEL, ESC, SP.
  - Printable range bounds.
- One sub-module: uart_rx_fifo, parameter DEPTH. Ports: clk, rst, push, din, pop, dout, empty, full, overflow.
- The line RAM and the FSM stay in uart_line_editor.

Test Plan:
- Prompt and echo:
  - Stimulus: get_a_cmd, then RX "ab\r"; consumer holds line_ready=0.
  - Required: TX "$ ab\r\n" in that order, each byte separated by a tx_busy gap; line_valid=1, line_len=2, RAM[0]=0x61, RAM[1]=0x62.
  - Then line_ready=1 for one cycle: line_valid=0 and idle=1 on the following cycle.
- Backspace:
  - RX "abc", 0x08, "\r": TX adds 0x08,0x20,0x08 after "c"; line_len=2.
  - RX 0x7F on an empty line: no TX activity.
- Line full, LINE_MAX=4:
  - RX "abcdef\r": TX "$ abcd", 0x07, 0x07, "\r\n"; line_len=4, RAM holds "abcd".
- Overflow, RBUF_DEPTH=4:
  - In IDLE, RX 5 bytes back-to-back: rx_overflow=1 and the FIFO holds the first 4.
  - A subsequent get_a_cmd echoes those 4 bytes.
  - Full-FIFO simultaneous push/pop: no drop.
- ESC and ECHO_EN=0:
  - RX ESC,"x","\r": ESC is silent, "x" is not echoed, TX "$ \r\n"; line_len=1.
- Reset mid-sequence:
  - Assert rst while in BS1: the next cycle shows tx_start=0, state IDLE, FIFO empty, line_valid=0, rx_overflow=0.
